// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its requester arbiter: opcodes, FSM encoding, width helper.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin priority encoder: first asserted request after 'last', wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    grant,
  output logic               any
);

  logic [ID_W-1:0] idx;

  // Scan last+1 .. last+NUM_REQ; the first hit wins, so 'last' itself has lowest priority.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ID_W'((int'(last) + off) % NUM_REQ);
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with round-robin grant and a
// valid/ready response channel carrying result, zero flag and owner ID.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int ANCHO_BUS = 32,
  parameter  int NUM_REQ   = 2,
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ANCHO_BUS-1:0]  req_data1,
  input  logic [NUM_REQ*ANCHO_BUS-1:0]  req_data2,
  input  logic [NUM_REQ*4-1:0]          req_op,
  output logic [ANCHO_BUS-1:0]          alu_data1,
  output logic [ANCHO_BUS-1:0]          alu_data2,
  output logic [3:0]                    alu_op,
  input  logic [ANCHO_BUS-1:0]          alu_result,
  input  logic                          alu_zero,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [ANCHO_BUS-1:0]          rsp_result,
  output logic                          rsp_zero,
  output logic                          busy
);

  arb_state_t            state_q, state_d;
  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       id_reg;
  logic [ID_W-1:0]       grant;
  logic                  any_req;
  logic                  grant_en;
  logic                  do_grant;

  logic [ANCHO_BUS-1:0]  d1 [NUM_REQ];
  logic [ANCHO_BUS-1:0]  d2 [NUM_REQ];
  logic [3:0]            op [NUM_REQ];

  // Unpack the flat request buses so the granted slice is a plain array index.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign d1[i] = req_data1[i*ANCHO_BUS +: ANCHO_BUS];
    assign d2[i] = req_data2[i*ANCHO_BUS +: ANCHO_BUS];
    assign op[i] = req_op[i*4 +: 4];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req   (req_valid),
    .last  (last_grant),
    .grant (grant),
    .any   (any_req)
  );

  // A grant can only happen when the ALU input registers are free to be reloaded.
  assign grant_en = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign do_grant = grant_en && any_req;
  assign busy     = (state_q != IDLE);

  // One-hot accept towards the winning requester, only in the grant cycle.
  always_comb begin
    req_ready = '0;
    if (do_grant) req_ready[grant] = 1'b1;
  end

  // Next-state logic: IDLE -> EXEC on grant, EXEC -> RESP, RESP drains or chains a new grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_grant) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = do_grant ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, ALU operand registers and response registers; reset drops any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alu_data1  <= '0;
      alu_data2  <= '0;
      alu_op     <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      id_reg     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
      state_q <= state_d;
      if (do_grant) begin
        alu_data1  <= d1[grant];
        alu_data2  <= d2[grant];
        alu_op     <= op[grant];
        last_grant <= grant;
        id_reg     <= grant;
      end
      if (state_q == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_id     <= id_reg;
        rsp_valid  <= 1'b1;
      end else if ((state_q == RESP) && rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and an expected-response scoreboard.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int N  = 2;
  localparam int IW = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_data1;
  logic [N*W-1:0]   req_data2;
  logic [N*4-1:0]   req_op;
  logic [W-1:0]     alu_data1;
  logic [W-1:0]     alu_data2;
  logic [3:0]       alu_op;
  logic [W-1:0]     alu_result;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic [W-1:0]     rsp_result;
  logic             rsp_zero;
  logic             busy;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  result;
    logic          zero;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.ANCHO_BUS(W), .NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data1  (req_data1),
    .req_data2  (req_data2),
    .req_op     (req_op),
    .alu_data1  (alu_data1),
    .alu_data2  (alu_data2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  // Behavioural stand-in for the shared combinational ALU.
  always_comb begin
    alu_result = 32'h0000_00CC;
    case (alu_op)
      ALU_AND: alu_result = alu_data1 & alu_data2;
      ALU_OR:  alu_result = alu_data1 | alu_data2;
      ALU_ADD: alu_result = alu_data1 + alu_data2;
      ALU_SUB: alu_result = alu_data1 - alu_data2;
      ALU_SLT: alu_result = ($signed(alu_data1) < $signed(alu_data2)) ? 32'd1 : 32'd0;
      ALU_XOR: alu_result = alu_data1 ^ alu_data2;
      default: alu_result = 32'h0000_00CC;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] o);
    req_data1[i*W +: W] = a;
    req_data2[i*W +: W] = b;
    req_op[i*4 +: 4]    = o;
  endtask

  task automatic push(input int id, input logic [W-1:0] r, input logic z);
    q.push_back('{id: IW'(id), result: r, zero: z});
  endtask

  // Compare the response channel against the oldest expected entry; optionally retire it.
  task automatic check_rsp(input string tag, input bit pop);
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed=empty scoreboard expected=pending entry", tag);
    end else begin
      e = pop ? q.pop_front() : q[0];
      check({tag, ".valid"},  rsp_valid,  1'b1);
      check({tag, ".id"},     rsp_id,     e.id);
      check({tag, ".result"}, rsp_result, e.result);
      check({tag, ".zero"},   rsp_zero,   e.zero);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data1 = '0;
    req_data2 = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    #12;
    check("rst.rsp_valid",  rsp_valid,  1'b0);
    check("rst.busy",       busy,       1'b0);
    check("rst.alu_data1",  alu_data1,  32'd0);
    check("rst.alu_op",     alu_op,     4'd0);
    check("rst.rsp_result", rsp_result, 32'd0);
    check("rst.rsp_id",     rsp_id,     1'b0);
    check("rst.req_ready",  req_ready,  2'b00);
    #1 rst_n = 1'b1;
    tick();

    // 1: single ADD from req0, latency grant T -> rsp_valid T+2.
    set_req(0, 32'd5, 32'd7, ALU_ADD);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    check("t1.grant", req_ready, 2'b01);
    push(0, 32'd12, 1'b0);
    tick();
    req_valid = 2'b00;
    #1;
    check("t1.exec_ready", req_ready, 2'b00);
    check("t1.exec_busy",  busy,      1'b1);
    check("t1.exec_valid", rsp_valid, 1'b0);
    check("t1.alu_data1",  alu_data1, 32'd5);
    check("t1.alu_data2",  alu_data2, 32'd7);
    check("t1.alu_op",     alu_op,    ALU_ADD);
    tick();
    check_rsp("t1.rsp", 1'b1);
    tick();
    check("t1.idle_valid", rsp_valid, 1'b0);
    check("t1.idle_busy",  busy,      1'b0);

    // 2: both requesters SUB 9-9 held valid, fresh reset so requester 0 wins first.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    set_req(0, 32'd9, 32'd9, ALU_SUB);
    set_req(1, 32'd9, 32'd9, ALU_SUB);
    req_valid = 2'b11;
    #1;
    check("t2.grant0", req_ready, 2'b01);
    push(0, 32'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2.exec_ready", req_ready, 2'b00);
      check("t2.exec_valid", rsp_valid, 1'b0);
      if (k == 3) req_valid = 2'b00;
      #1;
      tick();
      check_rsp("t2.rsp", 1'b1);
      if (k < 3) begin
        check("t2.rr_grant", req_ready, 2'b01 << ((k + 1) % 2));
        push((k + 1) % 2, 32'd0, 1'b1);
      end else begin
        check("t2.no_grant", req_ready, 2'b00);
      end
    end
    tick();
    check("t2.idle_busy", busy, 1'b0);

    // 3: backpressure with req1 pending; response frozen, then same-cycle regrant.
    set_req(0, 32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND);
    set_req(1, 32'h0F0F_0000, 32'h0000_00F0, ALU_OR);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    #1;
    check("t3.grant0", req_ready, 2'b01);
    push(0, 32'hF000_F000, 1'b0);
    tick();
    req_valid = 2'b10;
    #1;
    check("t3.exec_ready", req_ready, 2'b00);
    for (int c = 0; c < 5; c++) begin
      tick();
      check_rsp("t3.hold", 1'b0);
      check("t3.hold_ready", req_ready, 2'b00);
      check("t3.hold_busy",  busy,      1'b1);
    end
    rsp_ready = 1'b1;
    #1;
    check("t3.regrant", req_ready, 2'b10);
    check_rsp("t3.rsp0", 1'b1);
    push(1, 32'h0F0F_00F0, 1'b0);
    tick();
    req_valid = 2'b00;
    #1;
    check("t3.alu_op", alu_op, ALU_OR);
    tick();
    check_rsp("t3.rsp1", 1'b1);
    tick();

    // 4: undefined opcode gives the ALU default pattern; XOR of complementary halves.
    set_req(0, 32'h1234_5678, 32'h9ABC_DEF0, 4'b1111);
    set_req(1, 32'hFFFF_0000, 32'h0000_FFFF, ALU_XOR);
    req_valid = 2'b11;
    #1;
    check("t4.grant0", req_ready, 2'b01);
    push(0, 32'h0000_00CC, 1'b0);
    tick();
    check("t4.alu_op", alu_op, 4'b1111);
    tick();
    check_rsp("t4.undef", 1'b1);
    check("t4.grant1", req_ready, 2'b10);
    push(1, 32'hFFFF_FFFF, 1'b0);
    tick();
    req_valid = 2'b00;
    #1;
    tick();
    check_rsp("t4.xor", 1'b1);
    tick();

    // 5: reset during EXEC drops the transaction; afterwards requester 0 wins again.
    set_req(0, 32'd1, 32'd1, ALU_ADD);
    req_valid = 2'b01;
    #1;
    check("t5.grant0", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    check("t5.exec_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5.rst_valid", rsp_valid, 1'b0);
    check("t5.rst_busy",  busy,      1'b0);
    check("t5.rst_alu",   alu_data1, 32'd0);
    tick();
    check("t5.rst_hold_valid", rsp_valid, 1'b0);
    rst_n = 1'b1;
    set_req(0, 32'd1, 32'd2, ALU_ADD);
    set_req(1, 32'd3, 32'd4, ALU_ADD);
    req_valid = 2'b11;
    #1;
    check("t5.first_grant", req_ready, 2'b01);
    push(0, 32'd3, 1'b0);
    tick();
    req_valid = 2'b00;
    #1;
    tick();
    check_rsp("t5.rsp", 1'b1);
    tick();
    check("sb.empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
